quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, decodes Gray-code steps into a
// modulo position counter with direction, step and illegal-transition reporting.
module quad_decoder #(
  parameter int N_WIDTH    = 4,
  parameter int MOD        = (1 << N_WIDTH),
  parameter bit INVERT_DIR = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  input  logic               enable,
  input  logic               clear,
  output logic [N_WIDTH-1:0] pos,
  output logic               dir,
  output logic               step,
  output logic               err,
  output logic               err_sticky
);

  localparam logic [N_WIDTH-1:0] POS_MAX  = N_WIDTH'(MOD - 1);
  localparam logic [N_WIDTH-1:0] POS_ZERO = {N_WIDTH{1'b0}};
  localparam logic [N_WIDTH-1:0] POS_ONE  = N_WIDTH'(1);

  // Map Gray state 00,01,11,10 to phase 0,1,2,3 so steps become a modulo-4 delta.
  function automatic logic [1:0] gray_index(input logic [1:0] g);
    gray_index = {g[1], g[1] ^ g[0]};
  endfunction

  logic [1:0]         s1_r;
  logic [1:0]         s2_r;
  logic [1:0]         h_r;
  logic [1:0]         warm_cnt_r;
  logic [N_WIDTH-1:0] pos_r;
  logic               dir_r;
  logic               step_r;
  logic               err_r;
  logic               err_sticky_r;

  logic [1:0]         delta_s;
  logic               move_s;
  logic               fwd_s;
  logic               illegal_s;
  logic               up_s;
  logic               warm_done_s;
  logic [N_WIDTH-1:0] pos_next_s;

  assign delta_s     = gray_index(s2_r) - gray_index(h_r);
  assign warm_done_s = (warm_cnt_r == 2'd3);
  assign up_s        = fwd_s ^ INVERT_DIR;

  // Classify the transition between the previous and current synchronized state.
  always_comb begin
    move_s    = 1'b0;
    fwd_s     = 1'b0;
    illegal_s = 1'b0;
    case (delta_s)
      2'd1: begin
        move_s = 1'b1;
        fwd_s  = 1'b1;
      end
      2'd3: begin
        move_s = 1'b1;
        fwd_s  = 1'b0;
      end
      2'd2: illegal_s = 1'b1;
      default: begin
        move_s    = 1'b0;
        illegal_s = 1'b0;
      end
    endcase
  end

  // Next position with wrap at both ends of 0..MOD-1.
  always_comb begin
    pos_next_s = pos_r;
    if (up_s) begin
      if (pos_r == POS_MAX) begin
        pos_next_s = POS_ZERO;
      end else begin
        pos_next_s = pos_r + POS_ONE;
      end
    end else begin
      if (pos_r == POS_ZERO) begin
        pos_next_s = POS_MAX;
      end else begin
        pos_next_s = pos_r - POS_ONE;
      end
    end
  end

  // Synchronizer, history, warm-up and registered decode outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r         <= 2'b00;
      s2_r         <= 2'b00;
      h_r          <= 2'b00;
      warm_cnt_r   <= 2'd0;
      pos_r        <= POS_ZERO;
      dir_r        <= 1'b0;
      step_r       <= 1'b0;
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      s1_r  <= {a, b};
      s2_r  <= s1_r;
      h_r   <= s2_r;
      err_r <= warm_done_s & illegal_s;
      if (!warm_done_s) begin
        warm_cnt_r <= warm_cnt_r + 2'd1;
      end else begin
        warm_cnt_r <= warm_cnt_r;
      end
      // Clear wins over a coincident step and keeps the sticky flag low.
      if (clear) begin
        pos_r        <= POS_ZERO;
        err_sticky_r <= 1'b0;
        step_r       <= 1'b0;
      end else begin
        if (warm_done_s && illegal_s) begin
          err_sticky_r <= 1'b1;
        end else begin
          err_sticky_r <= err_sticky_r;
        end
        if (warm_done_s && enable && move_s) begin
          pos_r  <= pos_next_s;
          dir_r  <= ~up_s;
          step_r <= 1'b1;
        end else begin
          step_r <= 1'b0;
        end
      end
    end
  end

  assign pos        = pos_r;
  assign dir        = dir_r;
  assign step       = step_r;
  assign err        = err_r;
  assign err_sticky = err_sticky_r;

endmodule
